// File: rtl/aes_kd_sequencer.sv
// Sequences key and data loads between the UART controller and the AES core.
// It waits for the core's valid flags with a timeout and holds the ciphertext for transmission.
module aes_kd_sequencer #(
   parameter int TIMEOUT_CYCLES = 4095,
   parameter int DVLD_HOLD      = 8
) (
   input  logic         CLK,
   input  logic         NRST,
   input  logic         EN_IN,
   input  logic         RSTn_IN,
   input  logic [127:0] KIN_IN,
   input  logic [127:0] DIN_IN,
   input  logic         KDRDY_IN,
   output logic         EN_CORE,
   output logic         RSTn_CORE,
   output logic [127:0] KEY_CORE,
   output logic [127:0] DATA_CORE,
   output logic         KRDY_CORE,
   output logic         DRDY_CORE,
   input  logic [127:0] DOUT_CORE,
   input  logic         KVLD_CORE,
   input  logic         DVLD_CORE,
   input  logic         BUSY_CORE,
   output logic [127:0] DOUT_AES,
   output logic         KVLD_AES,
   output logic         DVLD_AES,
   output logic         BUSY_AES,
   output logic         ERR_AES
);

   typedef enum logic [2:0] {
      IDLE, KEY_REQ, KEY_WAIT, DATA_REQ, DATA_WAIT, DONE, ERROR
   } state_t;

   localparam logic [11:0] TIMEOUT_LIM = 12'(TIMEOUT_CYCLES);
   localparam logic [11:0] HOLD_LAST   = 12'(DVLD_HOLD - 1);

   state_t      state;
   state_t      state_next;
   logic [11:0] wait_cnt;
   logic [11:0] cnt_next;
   logic        kdrdy_prev;
   logic        request;
   logic        load;
   logic        capture;
   logic        kvld_hit;
   logic        busy_core_unused;

   assign busy_core_unused = BUSY_CORE;
   assign request = KDRDY_IN & ~kdrdy_prev & EN_IN;

   // The wait counter is shared: it times the two waits and then the DONE hold.
   always_comb begin
      state_next = state;
      cnt_next   = wait_cnt;
      load       = 1'b0;
      capture    = 1'b0;
      kvld_hit   = 1'b0;
      case (state)
         IDLE: begin
            if (request) begin
               state_next = KEY_REQ;
               load       = 1'b1;
            end
         end
         KEY_REQ: begin
            state_next = KEY_WAIT;
            cnt_next   = 12'd0;
         end
         KEY_WAIT: begin
            if (KVLD_CORE) begin
               state_next = DATA_REQ;
               kvld_hit   = 1'b1;
            end else if (wait_cnt == TIMEOUT_LIM) begin
               state_next = ERROR;
            end else begin
               cnt_next = wait_cnt + 12'd1;
            end
         end
         DATA_REQ: begin
            state_next = DATA_WAIT;
            cnt_next   = 12'd0;
         end
         DATA_WAIT: begin
            if (DVLD_CORE) begin
               state_next = DONE;
               capture    = 1'b1;
               cnt_next   = 12'd0;
            end else if (wait_cnt == TIMEOUT_LIM) begin
               state_next = ERROR;
            end else begin
               cnt_next = wait_cnt + 12'd1;
            end
         end
         DONE: begin
            if (wait_cnt == HOLD_LAST) begin
               state_next = IDLE;
            end else begin
               cnt_next = wait_cnt + 12'd1;
            end
         end
         ERROR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (!RSTn_IN) begin
         state_next = IDLE;
         cnt_next   = 12'd0;
         load       = 1'b0;
         capture    = 1'b0;
         kvld_hit   = 1'b0;
      end
   end

   // Strobes and status are registered decodes of the next state so they line up with it.
   always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
         state      <= IDLE;
         wait_cnt   <= 12'd0;
         kdrdy_prev <= 1'b0;
         EN_CORE    <= 1'b0;
         RSTn_CORE  <= 1'b0;
         KEY_CORE   <= '0;
         DATA_CORE  <= '0;
         KRDY_CORE  <= 1'b0;
         DRDY_CORE  <= 1'b0;
         DOUT_AES   <= '0;
         KVLD_AES   <= 1'b0;
         DVLD_AES   <= 1'b0;
         BUSY_AES   <= 1'b0;
         ERR_AES    <= 1'b0;
      end else begin
         state      <= state_next;
         wait_cnt   <= cnt_next;
         kdrdy_prev <= KDRDY_IN;
         EN_CORE    <= EN_IN;
         RSTn_CORE  <= RSTn_IN;
         KRDY_CORE  <= (state_next == KEY_REQ);
         DRDY_CORE  <= (state_next == DATA_REQ);
         DVLD_AES   <= (state_next == DONE);
         BUSY_AES   <= (state_next != IDLE);
         KVLD_AES   <= kvld_hit;
         if (load) begin
            KEY_CORE  <= KIN_IN;
            DATA_CORE <= DIN_IN;
         end
         if (capture) begin
            DOUT_AES <= DOUT_CORE;
         end
         if (load || !RSTn_IN) begin
            ERR_AES <= 1'b0;
         end else if (state_next == ERROR) begin
            ERR_AES <= 1'b1;
         end
      end
   end

endmodule
